// File: rtl/pixel_frame_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_frame_buffer : double-buffered 16x8 RGB store, flip at frame_end
// Revision 1.0
// ----------------------------------------------------------------------------
module pixel_frame_buffer #(
  parameter bit CLEAR_ON_FLIP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x,
  input  logic [2:0] y,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       valid,
  input  logic       flip,
  output logic       flipped,
  output logic       dropped,
  input  logic       frame_end,
  input  logic [3:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [7:0] rd_red,
  output logic [7:0] rd_green,
  output logic [7:0] rd_blue
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic [6:0]  clr_cnt_q, clr_cnt_d;
  logic        flipped_q, flipped_d;
  logic        dropped_q, dropped_d;
  logic [23:0] rd_data_q, rd_data_d;

  logic [23:0] bank0_mem [128];
  logic [23:0] bank1_mem [128];

  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [23:0] wr_data;
  logic [6:0]  rd_addr;

  assign rd_addr = {rd_y, rd_x};

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    clr_cnt_d   = clr_cnt_q;
    flipped_d   = 1'b0;
    dropped_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = {y, x};
    wr_data     = {red, green, blue};
    case (state_q)
      ST_IDLE: begin
        wr_en = valid;
        if (flip) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        dropped_d = valid;
        if (frame_end) begin
          front_sel_d = ~front_sel_q;
          if (CLEAR_ON_FLIP) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = 7'd0;
          end else begin
            state_d   = ST_IDLE;
            flipped_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        // Zero-fill the bank that just became back, one word per cycle.
        dropped_d = valid;
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        wr_data   = 24'd0;
        clr_cnt_d = clr_cnt_q + 7'd1;
        if (clr_cnt_q == 7'd127) begin
          state_d   = ST_IDLE;
          flipped_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = front_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      clr_cnt_q   <= 7'd0;
      flipped_q   <= 1'b0;
      dropped_q   <= 1'b0;
      rd_data_q   <= 24'd0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      clr_cnt_q   <= clr_cnt_d;
      flipped_q   <= flipped_d;
      dropped_q   <= dropped_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Writes always target the back bank, so they never collide with the read port.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (front_sel_q) bank0_mem[wr_addr] <= wr_data;
      else             bank1_mem[wr_addr] <= wr_data;
    end
  end

  assign flipped  = flipped_q;
  assign dropped  = dropped_q;
  assign rd_red   = rd_data_q[23:16];
  assign rd_green = rd_data_q[15:8];
  assign rd_blue  = rd_data_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pixel_frame_buffer : bench for both CLEAR_ON_FLIP variants, shared stimulus
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pixel_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x, rd_x;
  logic [2:0] y, rd_y;
  logic [7:0] red, green, blue;
  logic       valid, flip, frame_end;
  logic       flipped0, dropped0, flipped1, dropped1;
  logic [7:0] rr0, rg0, rb0, rr1, rg1, rb1;

  always #5 clk = ~clk;

  pixel_frame_buffer #(.CLEAR_ON_FLIP(1'b0)) u0 (
    .clk(clk), .rst(rst), .x(x), .y(y), .red(red), .green(green), .blue(blue),
    .valid(valid), .flip(flip), .flipped(flipped0), .dropped(dropped0),
    .frame_end(frame_end), .rd_x(rd_x), .rd_y(rd_y),
    .rd_red(rr0), .rd_green(rg0), .rd_blue(rb0)
  );

  pixel_frame_buffer #(.CLEAR_ON_FLIP(1'b1)) u1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .red(red), .green(green), .blue(blue),
    .valid(valid), .flip(flip), .flipped(flipped1), .dropped(dropped1),
    .frame_end(frame_end), .rd_x(rd_x), .rd_y(rd_y),
    .rd_red(rr1), .rd_green(rg1), .rd_blue(rb1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, two banks of pixels (-1 = never written).
  int mbank [2][2][128];
  int mfront [2];
  bit mpend [2];
  int mclr_left [2];
  bit ef [2], ed [2];
  int erd [2];

  int tickno = 0;
  int nflip0, ndrop0, nflip1;
  int flip_tick0, flip_tick1;

  typedef struct {
    logic [3:0]  vx;
    logic [2:0]  vy;
    logic [23:0] rgb;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at tick %0d", name, act, exp, tickno);
    end
  endtask

  task automatic model_step();
    int a, ra, bk;
    a  = int'({y, x});
    ra = int'({rd_y, rd_x});
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mfront[m] = 0; mpend[m] = 0; mclr_left[m] = 0;
        ef[m] = 0; ed[m] = 0; erd[m] = 0;
      end else begin
        bk     = 1 - mfront[m];
        erd[m] = mbank[m][mfront[m]][ra];
        ef[m]  = 0;
        ed[m]  = 0;
        if (mclr_left[m] > 0) begin
          mbank[m][bk][128 - mclr_left[m]] = 0;
          mclr_left[m]--;
          ed[m] = valid;
          ef[m] = (mclr_left[m] == 0);
        end else if (mpend[m]) begin
          ed[m] = valid;
          if (frame_end) begin
            mfront[m] = bk;
            mpend[m]  = 0;
            if (m == 1) mclr_left[m] = 128;
            else        ef[m] = 1;
          end
        end else begin
          if (valid) mbank[m][bk][a] = int'({red, green, blue});
          if (flip)  mpend[m] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    tickno++;
    check("u0.flipped", {31'd0, flipped0}, {31'd0, ef[0]});
    check("u0.dropped", {31'd0, dropped0}, {31'd0, ed[0]});
    check("u1.flipped", {31'd0, flipped1}, {31'd0, ef[1]});
    check("u1.dropped", {31'd0, dropped1}, {31'd0, ed[1]});
    if (erd[0] >= 0) check("u0.rd", {8'd0, rr0, rg0, rb0}, erd[0]);
    if (erd[1] >= 0) check("u1.rd", {8'd0, rr1, rg1, rb1}, erd[1]);
    if (flipped0) begin nflip0++; flip_tick0 = tickno; end
    if (flipped1) begin nflip1++; flip_tick1 = tickno; end
    if (dropped0) ndrop0++;
  endtask

  task automatic idle(input int n);
    valid = 0; flip = 0; frame_end = 0; rst = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_px(input logic [3:0] wx, input logic [2:0] wy, input logic [23:0] c);
    x = wx; y = wy; {red, green, blue} = c; valid = 1;
    tick();
    valid = 0;
  endtask

  task automatic do_flip(input int gap);
    flip = 1; tick(); flip = 0;
    idle(gap);
    frame_end = 1; tick(); frame_end = 0;
    idle(130);
  endtask

  task automatic fill(input int k);
    for (int a = 0; a < 128; a++)
      write_px(a[3:0], a[6:4], 24'((a * 32'h030507 + k * 32'h111111) & 32'hFFFFFF));
  endtask

  int tf;

  initial begin
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 128; a++) mbank[m][b][a] = -1;
    vecs[0] = '{4'd2,  3'd0, 24'hFF0000, 24'hFF0000};
    vecs[1] = '{4'd15, 3'd7, 24'h0000FF, 24'h0000FF};
    vecs[2] = '{4'd5,  3'd3, 24'h123456, 24'h123456};
    vecs[3] = '{4'd0,  3'd0, 24'h00FF00, 24'h00FF00};

    x = 0; y = 0; red = 0; green = 0; blue = 0; rd_x = 0; rd_y = 0;
    valid = 0; flip = 0; frame_end = 0; rst = 1;
    tick(); tick();
    check("reset.rd0", {8'd0, rr0, rg0, rb0}, 32'd0);
    check("reset.flipped1", {31'd0, flipped1}, 32'd0);
    idle(2);

    // Make both banks of both instances known.
    fill(1); do_flip(2);
    fill(2); do_flip(1);

    // Front/back isolation, then the directed pixel table across one swap.
    write_px(vecs[2].vx, vecs[2].vy, vecs[2].rgb);
    rd_x = 4'd5; rd_y = 3'd3; idle(1);
    check("isolation.u0", {8'd0, rr0, rg0, rb0} != {8'd0, vecs[2].rgb}, 32'd1);
    check("isolation.u1", {8'd0, rr1, rg1, rb1} != {8'd0, vecs[2].rgb}, 32'd1);
    for (int i = 0; i < 4; i++) write_px(vecs[i].vx, vecs[i].vy, vecs[i].rgb);
    nflip0 = 0; nflip1 = 0;
    flip = 1; tick(); flip = 0;
    idle(2);
    frame_end = 1; tick(); frame_end = 0; tf = tickno;
    idle(130);
    check("table.flip_time0", flip_tick0, tf);
    check("table.flip_time1", flip_tick1, tf + 128);
    check("table.nflip0", nflip0, 1);
    check("table.nflip1", nflip1, 1);
    for (int i = 0; i < 4; i++) begin
      rd_x = vecs[i].vx; rd_y = vecs[i].vy; tick();
      check($sformatf("table[%0d].u0", i), {8'd0, rr0, rg0, rb0}, {8'd0, vecs[i].exp});
      check($sformatf("table[%0d].u1", i), {8'd0, rr1, rg1, rb1}, {8'd0, vecs[i].exp});
    end

    // valid held for 4 cycles while a flip is pending.
    ndrop0 = 0;
    flip = 1; tick(); flip = 0;
    for (int i = 0; i < 4; i++) write_px(4'(i), 3'd1, 24'hDEAD00);
    idle(2);
    check("pending.drops", ndrop0, 4);
    frame_end = 1; tick(); frame_end = 0;
    idle(130);
    for (int i = 0; i < 4; i++) begin rd_x = 4'(i); rd_y = 3'd1; tick(); end

    // Clear-on-flip: AA fill, swap, swap again without writes.
    for (int a = 0; a < 128; a++) write_px(a[3:0], a[6:4], 24'hAAAAAA);
    do_flip(0);
    do_flip(0);
    for (int a = 0; a < 128; a++) begin
      rd_x = a[3:0]; rd_y = a[6:4]; tick();
      check("clear.u1", {8'd0, rr1, rg1, rb1}, 32'd0);
    end

    // flip with frame_end in the same cycle, then a second flip while pending.
    nflip0 = 0;
    flip = 1; frame_end = 1; tick();
    frame_end = 0; tick();
    flip = 0; idle(0);
    frame_end = 1; tick(); frame_end = 0; tf = tickno;
    idle(3);
    check("samecycle.nflip0", nflip0, 1);
    check("samecycle.when0", flip_tick0, tf);
    idle(130);

    // Reset while pending.
    nflip0 = 0; nflip1 = 0;
    flip = 1; tick(); flip = 0;
    idle(2);
    rst = 1; frame_end = 1; tick();
    check("rstpend.rd0", {8'd0, rr0, rg0, rb0}, 32'd0);
    check("rstpend.rd1", {8'd0, rr1, rg1, rb1}, 32'd0);
    rst = 0; frame_end = 0;
    idle(1);
    frame_end = 1; tick(); frame_end = 0;
    idle(5);
    check("rstpend.nflip0", nflip0, 0);
    check("rstpend.nflip1", nflip1, 0);
    do_flip(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      x = 4'($urandom); y = 3'($urandom);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      valid = 1'($urandom % 2);
      flip = ($urandom % 20) == 0;
      frame_end = ($urandom % 10) == 0;
      rd_x = 4'($urandom); rd_y = 3'($urandom);
      rst = ($urandom % 700) == 0;
      tick();
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
